// File: rtl/enc_seq_ctrl_if.sv
// Control/handshake bundle between the HV encoder sequencer and its neighbours
// (item-memory read port, bundling accumulator, encoded-HV register, classifier).
interface enc_seq_ctrl_if #(
  parameter int FW = 10
);
  logic          start;
  logic          feat_valid;
  logic          hv_ready;
  logic [FW-1:0] feat_idx;
  logic          acc_clear;
  logic          acc_en;
  logic          bundling_features;
  logic [3:0]    ctr;
  logic          busy;
  logic          hv_valid;
  logic          done;

  modport master (
    input  start, feat_valid, hv_ready,
    output feat_idx, acc_clear, acc_en, bundling_features, ctr, busy, hv_valid, done
  );

  modport slave (
    output start, feat_valid, hv_ready,
    input  feat_idx, acc_clear, acc_en, bundling_features, ctr, busy, hv_valid, done
  );
endinterface

// File: rtl/enc_seq_ctrl.sv
// Chunked HV encoder sequencer: per chunk, accumulate every feature, wait out the
// threshold latency, write one slice; after the last chunk hold the HV for the classifier.
module enc_seq_ctrl #(
  parameter int NUM_FEATURES = 617,
  parameter int NUM_CHUNKS   = 10,
  parameter int THRESH_LAT   = 1,
  parameter int FW           = $clog2(NUM_FEATURES)
) (
  input  logic            clk,
  input  logic            rst,
  enc_seq_ctrl_if.master  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCUM  = 3'd1;
  localparam logic [2:0] S_THRESH = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  localparam int TW = (THRESH_LAT > 1) ? $clog2(THRESH_LAT) : 1;
  localparam logic [FW-1:0] LAST_FEAT  = FW'(NUM_FEATURES - 1);
  localparam logic [3:0]    LAST_CHUNK = 4'(NUM_CHUNKS - 1);
  localparam logic [TW-1:0] LAST_T     = TW'(THRESH_LAT - 1);

  logic [2:0]    state;
  logic [FW-1:0] feat_idx;
  logic [3:0]    ctr;
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      feat_idx <= '0;
      ctr      <= '0;
      tcnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state    <= S_ACCUM;
            feat_idx <= '0;
            ctr      <= '0;
          end
        end
        S_ACCUM: begin
          if (bus.feat_valid) begin
            if (feat_idx == LAST_FEAT) begin
              feat_idx <= '0;
              tcnt     <= '0;
              state    <= S_THRESH;
            end else begin
              feat_idx <= feat_idx + 1'b1;
            end
          end
        end
        S_THRESH: begin
          if (tcnt == LAST_T) begin
            state <= S_WRITE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_WRITE: begin
          // Last slice holds ctr so the classifier sees the final chunk index.
          if (ctr >= LAST_CHUNK) begin
            state <= S_OUT;
          end else begin
            ctr   <= ctr + 1'b1;
            state <= S_ACCUM;
          end
        end
        S_OUT: begin
          if (bus.hv_ready) begin
            state <= S_IDLE;
            ctr   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Clear rides along with a non-final slice write so the next chunk starts from zero.
  assign bus.acc_clear = ((state == S_IDLE) && bus.start) ||
                         ((state == S_WRITE) && (ctr < LAST_CHUNK));
  assign bus.acc_en            = (state == S_ACCUM) && bus.feat_valid;
  assign bus.bundling_features = (state == S_WRITE);
  assign bus.feat_idx          = feat_idx;
  assign bus.ctr               = ctr;
  assign bus.busy              = (state != S_IDLE);
  assign bus.hv_valid          = (state == S_OUT);
  assign bus.done              = (state == S_OUT) && bus.hv_ready;

endmodule
